imm_ext_stage: RTL and testbench

IMM_EXT_STAGE -- requirements
Module: imm_ext_stage

---
 rtl/imm_ext_stage_if.sv | 24 ++
 rtl/imm_ext_stage.sv | 95 +++++++++
 tb/tb_imm_ext_stage.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_stage_if.sv
// Handshake bundle for imm_ext_stage: producer offers a raw immediate, consumer
// takes the extended result.
interface imm_ext_stage_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm_in;
    logic [1:0]       ext_op;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] imm_out;

    modport master (
        output in_valid, imm_in, ext_op, out_ready,
        input  in_ready, out_valid, imm_out
    );

    modport slave (
        input  in_valid, imm_in, ext_op, out_ready,
        output in_ready, out_valid, imm_out
    );
endinterface

// File: rtl/imm_ext_stage.sv
// Immediate extension stage: extends at input and buffers results in a
// two-entry (main + skid) FIFO so in_ready depends only on registered state.
module imm_ext_stage #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    imm_ext_stage_if.slave bus
);

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_ext_stage: OUT_W must be at least IN_W+2");
    end

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_res;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        sext = {{(OUT_W-IN_W){bus.imm_in[IN_W-1]}}, bus.imm_in};
        unique case (bus.ext_op)
            2'b00:   ext_res = {{(OUT_W-IN_W){1'b0}}, bus.imm_in};
            2'b01:   ext_res = sext;
            2'b10:   ext_res = {bus.imm_in, {(OUT_W-IN_W){1'b0}}};
            default: ext_res = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign bus.in_ready  = (state_q != StTwo);
    assign bus.out_valid = (state_q != StEmpty);
    assign bus.imm_out   = main_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StOne;
                    main_d  = ext_res;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    main_d = ext_res;
                end else if (in_xfer) begin
                    state_d = StTwo;
                    skid_d  = ext_res;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush discards held entries and whatever is offered this cycle.
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_imm_ext_stage;

    logic clk = 1'b0;
    logic reset;
    logic flush16;
    logic flush26;

    always #5 clk = ~clk;

    imm_ext_stage_if #(.IN_W(16), .OUT_W(32)) bus16 ();
    imm_ext_stage_if #(.IN_W(26), .OUT_W(32)) bus26 ();

    imm_ext_stage #(.IN_W(16), .OUT_W(32)) dut16 (
        .clk   (clk),
        .reset (reset),
        .flush (flush16),
        .bus   (bus16.slave)
    );

    imm_ext_stage #(.IN_W(26), .OUT_W(32)) dut26 (
        .clk   (clk),
        .reset (reset),
        .flush (flush26),
        .bus   (bus26.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Arithmetic model: interpret the field as signed/unsigned and scale.
    function automatic logic [31:0] ref_ext(input int in_w, input longint imm,
                                            input logic [1:0] op);
        longint s;
        longint r;
        s = (imm >= (longint'(1) <<< (in_w - 1))) ? imm - (longint'(1) <<< in_w) : imm;
        case (op)
            2'd0:    r = imm;
            2'd1:    r = s;
            2'd2:    r = imm * (longint'(1) <<< (32 - in_w));
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        flush16 = 1'b0; flush26 = 1'b0;
        bus16.in_valid = 1'b0; bus16.imm_in = '0; bus16.ext_op = '0; bus16.out_ready = 1'b0;
        bus26.in_valid = 1'b0; bus26.imm_in = '0; bus26.ext_op = '0; bus26.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid);
        end
        tests_run++;
        if (bus16.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus16.in_ready);
        end
        tests_run++;
        if (bus16.imm_out !== 32'h0) begin
            tests_failed++; $display("FAIL reset_imm_out: got %h want 0", bus16.imm_out);
        end
        tests_run++;
        if (dut16.skid_q !== 32'h0) begin
            tests_failed++; $display("FAIL reset_skid: got %h want 0", dut16.skid_q);
        end
        tests_run++;
        if (bus26.out_valid !== 1'b0 || bus26.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_wide: got v=%b r=%b want v=0 r=1", bus26.out_valid, bus26.in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_release: got %b want 0", bus16.out_valid);
        end
    endtask

    task automatic test_modes();
        logic [15:0] imms [4] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF};
        logic [1:0]  ops  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] exps [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFFFFFC};
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus16.in_valid = 1'b1;
            bus16.imm_in   = imms[i];
            bus16.ext_op   = ops[i];
            @(negedge clk);
            tests_run++;
            if (bus16.out_valid !== 1'b1 || bus16.imm_out !== exps[i] || bus16.in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL modes[%0d]: got v=%b out=%h r=%b want v=1 out=%h r=1",
                         i, bus16.out_valid, bus16.imm_out, bus16.in_ready, exps[i]);
            end
        end
        bus16.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL modes_drain: got %b want 0", bus16.out_valid);
        end
    endtask

    task automatic test_skid();
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.ext_op    = 2'b01;
        bus16.imm_in    = 16'h0001;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b1 || bus16.imm_out !== 32'h1 || bus16.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_first: got v=%b out=%h r=%b want v=1 out=1 r=1",
                     bus16.out_valid, bus16.imm_out, bus16.in_ready);
        end
        bus16.imm_in = 16'h0002;
        @(negedge clk);
        tests_run++;
        if (bus16.in_ready !== 1'b0 || bus16.imm_out !== 32'h1) begin
            tests_failed++;
            $display("FAIL skid_full: got r=%b out=%h want r=0 out=1", bus16.in_ready, bus16.imm_out);
        end
        bus16.imm_in = 16'h0003;
        @(negedge clk);
        tests_run++;
        if (bus16.in_ready !== 1'b0 || bus16.imm_out !== 32'h1) begin
            tests_failed++;
            $display("FAIL skid_hold: got r=%b out=%h want r=0 out=1", bus16.in_ready, bus16.imm_out);
        end
        bus16.out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus16.imm_out !== 32'h2 || bus16.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_second: got out=%h r=%b want out=2 r=1", bus16.imm_out, bus16.in_ready);
        end
        @(negedge clk);
        tests_run++;
        if (bus16.imm_out !== 32'h3 || bus16.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_third: got out=%h v=%b want out=3 v=1", bus16.imm_out, bus16.out_valid);
        end
        bus16.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL skid_drain: got %b want 0", bus16.out_valid);
        end
    endtask

    task automatic test_flush();
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.ext_op    = 2'b00;
        bus16.imm_in    = 16'h0011;
        @(negedge clk);
        bus16.imm_in = 16'h0022;
        @(negedge clk);
        tests_run++;
        if (bus16.in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL flush_setup: got r=%b want 0", bus16.in_ready);
        end
        flush16      = 1'b1;
        bus16.imm_in = 16'h0077;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: got v=%b r=%b want v=0 r=1", bus16.out_valid, bus16.in_ready);
        end
        flush16 = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus16.out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL flush_ghost[%0d]: got v=%b want 0", i, bus16.out_valid);
            end
        end
        bus16.in_valid = 1'b1;
        bus16.imm_in   = 16'h0055;
        @(negedge clk);
        tests_run++;
        if (bus16.imm_out !== 32'h55 || bus16.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_next: got out=%h v=%b want out=55 v=1", bus16.imm_out, bus16.out_valid);
        end
        bus16.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.ext_op    = 2'b00;
        bus16.imm_in    = 16'h1234;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_setup: got v=%b want 1", bus16.out_valid);
        end
        reset = 1'b1;
        flush16 = 1'b1;
        bus16.out_ready = 1'b1;
        bus16.imm_in    = 16'h4321;
        @(negedge clk);
        tests_run++;
        if (bus16.out_valid !== 1'b0 || bus16.imm_out !== 32'h0 || bus16.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid: got v=%b out=%h r=%b want v=0 out=0 r=1",
                     bus16.out_valid, bus16.imm_out, bus16.in_ready);
        end
        reset = 1'b0;
        flush16 = 1'b0;
        bus16.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus16.out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL rstmid_ghost[%0d]: got v=%b want 0", i, bus16.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        int          xfers  = 0;
        int          cycles = 0;
        logic        exp_rdy;
        logic        in_x;
        logic        out_x;
        logic [31:0] res;
        while (xfers < 10000 && cycles < 60000) begin
            exp_rdy = (q.size() < 2);
            tests_run++;
            if (bus16.out_valid !== (q.size() > 0) || bus16.in_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rand_flags@%0d: got v=%b r=%b want v=%b r=%b", cycles,
                         bus16.out_valid, bus16.in_ready, q.size() > 0, exp_rdy);
            end
            if (q.size() > 0) begin
                tests_run++;
                if (bus16.imm_out !== q[0]) begin
                    tests_failed++;
                    $display("FAIL rand_data@%0d: got %h want %h", cycles, bus16.imm_out, q[0]);
                end
            end
            bus16.in_valid  = 1'($urandom_range(0, 1));
            bus16.out_ready = 1'($urandom_range(0, 1));
            bus16.imm_in    = 16'($urandom);
            bus16.ext_op    = 2'($urandom_range(0, 3));
            res   = ref_ext(16, longint'(bus16.imm_in), bus16.ext_op);
            in_x  = bus16.in_valid && exp_rdy;
            out_x = bus16.out_ready && (q.size() > 0);
            #1 bus16.out_ready = ~bus16.out_ready;
            #1;
            tests_run++;
            if (bus16.in_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rand_rdy_path@%0d: got r=%b want %b", cycles, bus16.in_ready, exp_rdy);
            end
            bus16.out_ready = ~bus16.out_ready;
            if (out_x) begin
                void'(q.pop_front());
                xfers++;
            end
            if (in_x) q.push_back(res);
            @(negedge clk);
            cycles++;
        end
        tests_run++;
        if (xfers < 10000) begin
            tests_failed++; $display("FAIL rand_budget: got %0d transfers want 10000", xfers);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wide();
        logic [31:0] exps [4] = '{32'h02000000, 32'hFE000000, 32'h80000000, 32'hF8000000};
        logic [31:0] want;
        bus26.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus26.in_valid = 1'b1;
            bus26.imm_in   = 26'h2000000;
            bus26.ext_op   = 2'(i);
            @(negedge clk);
            tests_run++;
            if (bus26.out_valid !== 1'b1 || bus26.imm_out !== exps[i]) begin
                tests_failed++;
                $display("FAIL wide[%0d]: got v=%b out=%h want v=1 out=%h",
                         i, bus26.out_valid, bus26.imm_out, exps[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            bus26.imm_in = 26'($urandom);
            bus26.ext_op = 2'($urandom_range(0, 3));
            want = ref_ext(26, longint'(bus26.imm_in), bus26.ext_op);
            @(negedge clk);
            tests_run++;
            if (bus26.imm_out !== want) begin
                tests_failed++;
                $display("FAIL wide_rand[%0d]: got %h want %h", i, bus26.imm_out, want);
            end
        end
        bus26.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus26.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL wide_drain: got %b want 0", bus26.out_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_modes();
        test_skid();
        test_flush();
        test_reset_mid();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
